uart_tx_arbiter: RTL and testbench

//  Bus master that shares the memory-mapped UART transmit path between NUM_REQ byte-stream requesters.

---
 rtl/uart_tx_arb_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_rr.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and UART register offsets for the UART transmit arbiter.
package uart_tx_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_POLL,
        S_POLL_GAP,
        S_WRITE,
        S_WRITE_GAP,
        S_SEND,
        S_SEND_GAP
    } arb_state_t;

    localparam logic [31:0] OFF_TX_FULL = 32'h0000_000C;
    localparam logic [31:0] OFF_TX_SEND = 32'h0000_0010;
    localparam logic [31:0] OFF_TX_FIFO = 32'h0000_0014;
    localparam logic [31:0] TX_SEND_CMD = 32'h0000_0001;

    function automatic logic [31:0] fifo_word(input logic [7:0] b);
        return {24'b0, b};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first requester after last_ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_ptr,
    output logic [NUM_REQ-1:0]         grant_oh,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDW = $clog2(NUM_REQ);

    int idx;

    // Scan from last_ptr+1 with wrap; the previous winner is examined last.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        idx       = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = int'(last_ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == idx && req[i] && grant_oh == '0) begin
                    grant_oh[i] = 1'b1;
                    grant_idx   = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin master for the MMIO UART transmit window.
// Optional owner-idle timeout is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int          NUM_REQ        = 2,
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF_0120,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       m_read,
    output logic                       m_write,
    output logic [31:0]                m_addr,
    output logic [31:0]                m_wdata,
    input  logic                       m_done,
    input  logic [31:0]                m_rdata,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_flag
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_t       state, state_next;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   arb_idx;
    logic [NUM_REQ-1:0] arb_onehot;
    logic             arb_valid;
    logic             full_q;
    logic             last_q;
    logic [7:0]       data_q;
    logic             owner_valid;
    logic             owner_last;
    logic [7:0]       owner_byte;
    logic             tmo_hit;
    logic             unused_rdata;

    assign unused_rdata = ^m_rdata[31:1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req       (req_valid),
        .last_ptr  (rr_ptr),
        .grant_oh  (arb_onehot),
        .grant_idx (arb_idx)
    );

    assign arb_valid   = |arb_onehot;
    assign owner_valid = req_valid[grant_id];
    assign owner_last  = req_last[grant_id];
    assign owner_byte  = req_data[{grant_id, 3'b000} +: 8];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCW-1:0] tmo_cnt;
    logic           tmo_idle;

    assign tmo_idle = busy && (state == S_POLL_GAP) && !owner_valid;
    assign tmo_hit  = tmo_idle && (tmo_cnt == TCW'(TIMEOUT_CYCLES - 1));

    // Idle time of a stalled owner; any accepted byte restarts the count.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == S_IDLE || (state == S_WRITE && m_done)) begin
                tmo_cnt <= '0;
            end else if (tmo_idle) begin
                tmo_cnt <= tmo_cnt + TCW'(1);
            end
            if (tmo_hit) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign tmo_hit      = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            full_q   <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_ARB: begin
                    if (arb_valid) begin
                        grant_id <= arb_idx;
                        busy     <= 1'b1;
                    end
                end
                S_POLL: begin
                    if (m_done) begin
                        full_q <= m_rdata[0];
                    end
                end
                S_POLL_GAP: begin
                    if (state_next == S_WRITE) begin
                        data_q <= owner_byte;
                    end
                end
                S_WRITE: begin
                    if (m_done) begin
                        last_q <= owner_last;
                    end
                end
                S_SEND: begin
                    if (m_done) begin
                        rr_ptr <= grant_id;
                        busy   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every access holds until m_done and is followed by one idle gap state.
    always_comb begin
        state_next = state;
        m_read     = 1'b0;
        m_write    = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        req_ready  = '0;
        case (state)
            S_IDLE: begin
                if (|req_valid) begin
                    state_next = S_ARB;
                end
            end
            S_ARB: begin
                state_next = arb_valid ? S_POLL : S_IDLE;
            end
            S_POLL: begin
                m_read = 1'b1;
                m_addr = BASE_ADDR + OFF_TX_FULL;
                if (m_done) begin
                    state_next = S_POLL_GAP;
                end
            end
            S_POLL_GAP: begin
                if (tmo_hit) begin
                    state_next = S_SEND;
                end else if (full_q) begin
                    state_next = S_POLL;
                end else if (owner_valid) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                m_write = 1'b1;
                m_addr  = BASE_ADDR + OFF_TX_FIFO;
                m_wdata = fifo_word(data_q);
                if (m_done) begin
                    req_ready[grant_id] = 1'b1;
                    state_next          = S_WRITE_GAP;
                end
            end
            S_WRITE_GAP: begin
                state_next = last_q ? S_SEND : S_POLL;
            end
            S_SEND: begin
                m_write = 1'b1;
                m_addr  = BASE_ADDR + OFF_TX_SEND;
                m_wdata = TX_SEND_CMD;
                if (m_done) begin
                    state_next = S_SEND_GAP;
                end
            end
            S_SEND_GAP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: MMIO slave model, byte-queue requesters and a packet-order reference model.
module tb_uart_tx_arbiter;

    localparam int          NUM_REQ = 3;
    localparam int          IDW     = 2;
    localparam int          TMO     = 16;
    localparam logic [31:0] BASE    = 32'hFFFF_0120;
    localparam logic [31:0] A_FULL  = BASE + 32'h0C;
    localparam logic [31:0] A_SEND  = BASE + 32'h10;
    localparam logic [31:0] A_FIFO  = BASE + 32'h14;

    logic                 sys_clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 m_read;
    logic                 m_write;
    logic [31:0]          m_addr;
    logic [31:0]          m_wdata;
    logic                 m_done;
    logic [31:0]          m_rdata;
    logic [IDW-1:0]       grant_id;
    logic                 busy;
    logic                 timeout_flag;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_done       (m_done),
        .m_rdata      (m_rdata),
        .grant_id     (grant_id),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          owner;
    } exp_t;

    exp_t        expq[$];
    logic [8:0]  rq[NUM_REQ][$];
    logic        full_seq[$];

    int          checks = 0;
    int          errors = 0;
    int          model_rr = 0;
    int          cnt = 0;
    int          lat = 1;
    int          lat_fixed = 1;
    bit          stray_en = 0;
    bit          gap_pending = 0;
    bit          hold_rd = 0;
    logic [31:0] hold_addr = 0;
    logic [31:0] hold_wdata = 0;
    logic        last_full = 0;
    int          reads_since = 0;
    int          ones_since = 0;
    int          cyc = 0;
    bit          in_write = 0;
    int          last_ready_cyc = 0;
    int          send_start_cyc = -1;
    logic        tflag_exp = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Queue one packet of len bytes on requester id; base < 0 gives random bytes.
    task automatic applyStimulus(input int id, input int len, input int base);
        logic [7:0] b;
        for (int k = 0; k < len; k++) begin
            b = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + k);
            rq[id].push_back({(k == len - 1), b});
        end
    endtask

    task automatic driveReq();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rq[i].size() > 0) begin
                {req_last[i], req_data[8*i +: 8]} = rq[i][0];
                req_valid[i] = 1'b1;
            end else begin
                req_valid[i]       = 1'b0;
                req_last[i]        = 1'b0;
                req_data[8*i +: 8] = 8'h00;
            end
        end
    endtask

    // Whole packets leave in round-robin order after the previous winner.
    task automatic buildExpected();
        logic [8:0] tmp[NUM_REQ][$];
        logic [8:0] b;
        exp_t       e;
        int         own;
        int         c;
        for (int i = 0; i < NUM_REQ; i++) tmp[i] = rq[i];
        forever begin
            own = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (model_rr + k) % NUM_REQ;
                if (own < 0 && tmp[c].size() > 0) own = c;
            end
            if (own < 0) break;
            do begin
                b       = tmp[own].pop_front();
                e.addr  = A_FIFO;
                e.data  = {24'b0, b[7:0]};
                e.owner = own;
                expq.push_back(e);
            end while (!b[8] && tmp[own].size() > 0);
            e.addr  = A_SEND;
            e.data  = 32'h1;
            e.owner = own;
            expq.push_back(e);
            model_rr = own;
        end
    endtask

    task automatic stepCycle();
        logic [NUM_REQ-1:0] rdy;
        logic               act;
        logic               done_nx;
        logic [31:0]        rd_nx;
        logic [31:0]        r;
        logic               fifo_done;
        exp_t               e;
        @(negedge sys_clk);
        cyc++;
        rdy       = req_ready;
        act       = m_read | m_write;
        done_nx   = 1'b0;
        r         = $urandom;
        rd_nx     = r;
        fifo_done = 1'b0;
        if (act) checkOutput("rw_excl", 32'(m_read & m_write), 0);
        if (m_done && cnt > 0) begin
            checkOutput("held_to_done", 32'(act), 1);
            if (hold_rd) begin
                checkOutput("poll_addr", hold_addr, A_FULL);
                reads_since++;
                ones_since += int'(last_full);
            end else begin
                checkOutput("exp_avail", 32'(expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    checkOutput("w_addr", hold_addr, e.addr);
                    checkOutput("w_data", hold_wdata, e.data);
                    checkOutput("grant", 32'(grant_id), 32'(e.owner));
                    checkOutput("busy", 32'(busy), 1);
                    if (e.addr == A_FIFO) begin
                        fifo_done = 1'b1;
                        checkOutput("ready", 32'(rdy), 32'(1) << e.owner);
                        checkOutput("polls", reads_since, ones_since + 1);
                        reads_since = 0;
                        ones_since  = 0;
                    end
                end
            end
            cnt         = 0;
            gap_pending = 1;
            if (stray_en && $urandom_range(0, 3) == 0) done_nx = 1'b1;
        end else if (gap_pending) begin
            checkOutput("gap", 32'(act), 0);
            gap_pending = 0;
        end else if (act) begin
            if (cnt == 0) begin
                hold_rd    = m_read;
                hold_addr  = m_addr;
                hold_wdata = m_wdata;
                lat        = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, 3);
                if (m_write && m_addr == A_FIFO) in_write = 1;
                if (m_write && m_addr == A_SEND && send_start_cyc < 0) send_start_cyc = cyc;
            end else begin
                checkOutput("stable_addr", m_addr, hold_addr);
                checkOutput("stable_wdata", m_wdata, hold_wdata);
                checkOutput("stable_rd", 32'(m_read), 32'(hold_rd));
            end
            cnt++;
            if (cnt == lat) begin
                done_nx = 1'b1;
                if (hold_rd) begin
                    last_full = (full_seq.size() > 0) ? full_seq.pop_front() : 1'b0;
                    rd_nx     = {r[31:1], last_full};
                end
            end
        end else if (cnt > 0) begin
            checkOutput("dropped_req", 32'(act), 1);
            cnt = 0;
        end
        if (rdy != 0) begin
            last_ready_cyc = cyc;
            if (!fifo_done) checkOutput("stray_ready", 32'(rdy), 0);
        end
        @(posedge sys_clk);
        #1;
        m_done  = done_nx;
        m_rdata = rd_nx;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rdy[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        driveReq();
    endtask

    function automatic bit allIdle();
        bit idle;
        idle = (expq.size() == 0) && !busy && (cnt == 0);
        for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) idle = 0;
        return idle;
    endfunction

    task automatic runScenario(input int budget, input bit build);
        int n;
        n = 0;
        if (build) buildExpected();
        driveReq();
        while (n < budget && !allIdle()) begin
            stepCycle();
            n++;
        end
        checkOutput("in_budget", 32'(n < budget), 1);
        checkOutput("drain_left", expq.size(), 0);
        checkOutput("busy_end", 32'(busy), 0);
        checkOutput("tflag", 32'(timeout_flag), 32'(tflag_exp));
    endtask

    initial begin
        int n;
        int w_cyc;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        m_done    = 1'b0;
        m_rdata   = '0;
        #3;
        checkOutput("rst_read", 32'(m_read), 0);
        checkOutput("rst_write", 32'(m_write), 0);
        checkOutput("rst_addr", m_addr, 0);
        checkOutput("rst_wdata", m_wdata, 0);
        checkOutput("rst_ready", 32'(req_ready), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_grant", 32'(grant_id), 0);
        checkOutput("rst_tflag", 32'(timeout_flag), 0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        $display("[TB] three-byte packet from requester 0");
        lat_fixed = 1;
        applyStimulus(0, 3, 'h41);
        runScenario(200, 1);

        $display("[TB] two requesters contend");
        applyStimulus(0, 2, 'h10);
        applyStimulus(1, 3, 'h20);
        runScenario(400, 1);

        $display("[TB] TX FULL for five polls");
        for (int k = 0; k < 5; k++) full_seq.push_back(1'b1);
        applyStimulus(1, 1, 'h77);
        runScenario(200, 1);

        $display("[TB] slow slave");
        lat_fixed = 10;
        applyStimulus(2, 2, 'h90);
        runScenario(300, 1);

        $display("[TB] reset during a FIFO write");
        lat_fixed = 4;
        in_write  = 0;
        applyStimulus(2, 2, 'hC0);
        buildExpected();
        driveReq();
        n = 0;
        while (!in_write && n < 100) begin
            stepCycle();
            n++;
        end
        checkOutput("reached_write", 32'(in_write), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_write", 32'(m_write), 0);
        checkOutput("rst_mid_read", 32'(m_read), 0);
        checkOutput("rst_mid_busy", 32'(busy), 0);
        checkOutput("rst_mid_ready", 32'(req_ready), 0);
        for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
        expq.delete();
        model_rr    = 0;
        cnt         = 0;
        gap_pending = 0;
        reads_since = 0;
        ones_since  = 0;
        m_done      = 1'b0;
        driveReq();
        @(negedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        m_done = 1'b1;
        @(posedge sys_clk);
        #1;
        m_done = 1'b0;
        @(negedge sys_clk);
        checkOutput("post_rst_busy", 32'(busy), 0);
        checkOutput("post_rst_rw", 32'(m_read | m_write), 0);
        @(posedge sys_clk);
        #1;
        lat_fixed = 1;
        applyStimulus(0, 1, 'hA0);
        applyStimulus(1, 1, 'hB0);
        runScenario(200, 1);

        $display("[TB] randomized traffic");
        lat_fixed = 0;
        stray_en  = 1;
        for (int round = 0; round < 20; round++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                for (int p = $urandom_range(0, 2); p > 0; p--) begin
                    applyStimulus(i, $urandom_range(1, 4), -1);
                end
            end
            for (int k = $urandom_range(0, 2); k > 0; k--) full_seq.push_back(1'b1);
            runScenario(3000, 1);
        end

`ifdef UART_ARB_TIMEOUT_EN
        begin
            exp_t e;
            $display("[TB] owner stalls mid-packet");
            lat_fixed = 1;
            stray_en  = 0;
            full_seq.delete();
            rq[0].push_back({1'b0, 8'h55});
            e.addr  = A_FIFO;
            e.data  = 32'h55;
            e.owner = 0;
            expq.push_back(e);
            e.addr  = A_SEND;
            e.data  = 32'h1;
            expq.push_back(e);
            send_start_cyc = -1;
            driveReq();
            n = 0;
            while (rq[0].size() > 0 && n < 100) begin
                stepCycle();
                n++;
            end
            w_cyc = last_ready_cyc;
            checkOutput("tmo_flag_pre", 32'(timeout_flag), 0);
            applyStimulus(1, 2, 'h60);
            buildExpected();
            tflag_exp = 1'b1;
            runScenario(400, 0);
            checkOutput("tmo_delay", send_start_cyc - w_cyc, TMO + 4);
        end
`else
        w_cyc = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
